gpio_irq: RTL and testbench

- Memory-mapped edge-detect and interrupt block for the GP inputs, sitting downstream of the pins and beside the GPIO register block on the same device bus.
- Synchronises gp_i, detects per-bit rising and falling edges, and latches enabled edges into a W1C status register.
- Drives a single level interrupt to the core, and counts interrupt-causing events.

---
 rtl/gpio_irq_pkg.sv | 37 +++
 rtl/gpio_irq_if.sv | 17 +
 rtl/gpio_edge_detect.sv | 42 ++++
 rtl/gpio_irq.sv | 124 ++++++++++++
 tb/tb_gpio_irq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO edge/interrupt block: register offsets,
// the read-select encoding and the offset decoder.
package gpio_irq_pkg;

    localparam logic [31:0] RISE_EN_OFF = 32'h000;
    localparam logic [31:0] FALL_EN_OFF = 32'h004;
    localparam logic [31:0] STATUS_OFF  = 32'h008;
    localparam logic [31:0] IRQ_EN_OFF  = 32'h00C;
    localparam logic [31:0] EVT_CNT_OFF = 32'h010;
    localparam logic [31:0] LEVEL_OFF   = 32'h014;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RISE_EN,
        SEL_FALL_EN,
        SEL_STATUS,
        SEL_IRQ_EN,
        SEL_EVT_CNT,
        SEL_LEVEL
    } reg_sel_e;

    // Map a decoded offset onto a register select; anything else is unmapped.
    function automatic reg_sel_e decode_sel(input logic [31:0] off);
        reg_sel_e sel;
        case (off)
            RISE_EN_OFF: sel = SEL_RISE_EN;
            FALL_EN_OFF: sel = SEL_FALL_EN;
            STATUS_OFF:  sel = SEL_STATUS;
            IRQ_EN_OFF:  sel = SEL_IRQ_EN;
            EVT_CNT_OFF: sel = SEL_EVT_CNT;
            LEVEL_OFF:   sel = SEL_LEVEL;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// Device bus seen by the GPIO interrupt block: single-cycle request with a
// registered response one cycle later.
interface gpio_irq_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) ();
    logic                 req;
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [3:0]           be;
    logic [DataWidth-1:0] wdata;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;

    modport master (output req, addr, we, be, wdata, input rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output rvalid, rdata);
endinterface

// File: rtl/gpio_edge_detect.sv
// Two-flop synchroniser for asynchronous inputs plus a history flop, giving
// the synchronised level and single-cycle rise/fall pulses per bit.
module gpio_edge_detect #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] sync_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    logic [Width-1:0] sync1_q, sync1_d;
    logic [Width-1:0] sync2_q, sync2_d;
    logic [Width-1:0] prev_q, prev_d;

    // Shift the pin through the synchroniser and into the history stage.
    always_comb begin
        sync1_d = d_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Stage registers; reset clears history so a high pin at release is a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/gpio_irq.sv
// Edge-detect interrupt block for the GP inputs: per-bit rise/fall enables,
// W1C status, level interrupt and a saturating event counter on the device bus.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int GpiWidth  = 8,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int RegAddr   = 12,
    parameter int CntWidth  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    gpio_irq_if.slave           bus,
    input  logic [GpiWidth-1:0] gp_i,
    output logic                irq_o
);

    logic [AddrWidth-1:0] addr;
    logic [GpiWidth-1:0]  level, rise, fall, evt;
    logic [GpiWidth-1:0]  be_mask, wdata_g, w1c_mask;
    logic                 wr_en, rd_en;
    reg_sel_e             sel;

    logic [GpiWidth-1:0]  rise_en_q, rise_en_d;
    logic [GpiWidth-1:0]  fall_en_q, fall_en_d;
    logic [GpiWidth-1:0]  irq_en_q, irq_en_d;
    logic [GpiWidth-1:0]  status_q, status_d;
    logic [CntWidth-1:0]  evt_cnt_q, evt_cnt_d;
    logic                 irq_q, irq_d;
    logic                 rvalid_q, rvalid_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    // Only the low address bits are decoded; the rest are don't-care.
    logic unused_bus;
    assign unused_bus = ^{addr, bus.wdata, bus.be};

    gpio_edge_detect #(.Width(GpiWidth)) u_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (gp_i),
        .sync_o (level),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign addr    = bus.addr;
    assign sel     = bus.req ? decode_sel(32'(addr[RegAddr-1:0])) : SEL_NONE;
    assign wr_en   = bus.req & bus.we;
    assign rd_en   = bus.req & ~bus.we;
    assign wdata_g = bus.wdata[GpiWidth-1:0];
    assign evt     = (rise & rise_en_q) | (fall & fall_en_q);

    // Each implemented bit follows the enable of the byte lane it lives in.
    for (genvar i = 0; i < GpiWidth; i++) begin : g_be_mask
        assign be_mask[i] = bus.be[i/8];
    end

    // Register next-state: byte-masked RW writes, W1C status where a fresh
    // event always wins over a clear, and a saturating counter.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        w1c_mask  = '0;
        evt_cnt_d = evt_cnt_q;
        if (wr_en && sel == SEL_RISE_EN) rise_en_d = (rise_en_q & ~be_mask) | (wdata_g & be_mask);
        if (wr_en && sel == SEL_FALL_EN) fall_en_d = (fall_en_q & ~be_mask) | (wdata_g & be_mask);
        if (wr_en && sel == SEL_IRQ_EN)  irq_en_d  = (irq_en_q & ~be_mask) | (wdata_g & be_mask);
        if (wr_en && sel == SEL_STATUS)  w1c_mask  = wdata_g & be_mask;
        status_d = (status_q & ~w1c_mask) | evt;
        if (wr_en && sel == SEL_EVT_CNT) begin
            evt_cnt_d = CntWidth'(|evt);
        end else if (|evt && evt_cnt_q != '1) begin
            evt_cnt_d = evt_cnt_q + CntWidth'(1);
        end
        irq_d = |(status_d & irq_en_q);
    end

    // Read mux samples register values as they stand before this edge.
    always_comb begin
        rvalid_d = bus.req;
        rdata_d  = '0;
        if (rd_en) begin
            case (sel)
                SEL_RISE_EN: rdata_d[GpiWidth-1:0] = rise_en_q;
                SEL_FALL_EN: rdata_d[GpiWidth-1:0] = fall_en_q;
                SEL_STATUS:  rdata_d[GpiWidth-1:0] = status_q;
                SEL_IRQ_EN:  rdata_d[GpiWidth-1:0] = irq_en_q;
                SEL_EVT_CNT: rdata_d[CntWidth-1:0] = evt_cnt_q;
                SEL_LEVEL:   rdata_d[GpiWidth-1:0] = level;
                default:     rdata_d = '0;
            endcase
        end
    end

    // State and response registers; reset drops any in-flight request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
            status_q  <= '0;
            evt_cnt_q <= '0;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_en_q  <= irq_en_d;
            status_q  <= status_d;
            evt_cnt_q <= evt_cnt_d;
            irq_q     <= irq_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign irq_o      = irq_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq: directed scenarios with literal expectations, then
// random traffic compared every cycle against a register-level model.
module tb_gpio_irq;

    localparam int GW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [GW-1:0] gp = '0;
    logic          irq;
    logic          chk_on = 1'b0;
    int            n_chk = 0;
    int            n_pass = 0;

    gpio_irq_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    gpio_irq #(
        .GpiWidth (GW),
        .AddrWidth(32),
        .DataWidth(32),
        .RegAddr  (12),
        .CntWidth (CW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave),
        .gp_i  (gp),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [2:0][GW-1:0] hist;   // pin value seen at the last three edges, [0] newest
        logic [GW-1:0]      rise_en;
        logic [GW-1:0]      fall_en;
        logic [GW-1:0]      irq_en;
        logic [GW-1:0]      status;
        logic [CW-1:0]      cnt;
        logic               irq;
        logic               rvalid;
        logic [31:0]        rdata;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s, input logic req, input logic we,
                                           input logic [31:0] addr, input logic [3:0] be,
                                           input logic [31:0] wdata, input logic [GW-1:0] pin);
        mstate_t       n;
        logic [GW-1:0] lvl, prv, bm, wd, evt, merged;
        int            off;
        n   = s;
        lvl = s.hist[1];
        prv = s.hist[2];
        off = int'(addr[11:0]);
        for (int i = 0; i < GW; i++) bm[i] = be[i/8];
        wd     = wdata[GW-1:0];
        merged = '0;
        evt    = (lvl & ~prv & s.rise_en) | (~lvl & prv & s.fall_en);
        n.rvalid = req;
        n.rdata  = 32'h0;
        if (req && !we) begin
            case (off)
                'h00: n.rdata = 32'(s.rise_en);
                'h04: n.rdata = 32'(s.fall_en);
                'h08: n.rdata = 32'(s.status);
                'h0C: n.rdata = 32'(s.irq_en);
                'h10: n.rdata = 32'(s.cnt);
                'h14: n.rdata = 32'(lvl);
                default: n.rdata = 32'h0;
            endcase
        end
        if (req && we && off == 'h08) n.status = (s.status & ~(wd & bm)) | evt;
        else                          n.status = s.status | evt;
        if (req && we && off == 'h10)              n.cnt = (evt != 0) ? CW'(1) : CW'(0);
        else if (evt != 0 && s.cnt != {CW{1'b1}})  n.cnt = s.cnt + CW'(1);
        n.irq = (n.status & s.irq_en) != 0;
        if (req && we) begin
            case (off)
                'h00: begin merged = (s.rise_en & ~bm) | (wd & bm); n.rise_en = merged; end
                'h04: begin merged = (s.fall_en & ~bm) | (wd & bm); n.fall_en = merged; end
                'h0C: begin merged = (s.irq_en & ~bm) | (wd & bm);  n.irq_en = merged;  end
                default: ;
            endcase
        end
        n.hist = {s.hist[1], s.hist[0], pin};
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, bus.req, bus.we, bus.addr, bus.be, bus.wdata, gp);
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("irq_o", 32'(irq), 32'(m.irq));
            chk("rvalid", 32'(bus.rvalid), 32'(m.rvalid));
            if (m.rvalid) chk("rdata", bus.rdata, m.rdata);
        end
    end

    // ---------------- bus tasks (called positioned just after a negedge) ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.be = be; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a; bus.be = 4'hF; bus.wdata = '0;
        @(negedge clk);
        chk({name, "_rvalid"}, 32'(bus.rvalid), 32'h1);
        chk(name, bus.rdata, exp);
        bus.req = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int offs[8] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h20, 'h18};

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
        wait_n(3);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Rising edge on bit0 with interrupt enabled.
        wr(32'h00, 32'h01, 4'hF);
        wr(32'h0C, 32'h01, 4'hF);
        gp[0] = 1'b1;
        wait_n(3);
        rd_chk("t1_status", 32'h08, 32'h01);
        chk("t1_irq", 32'(irq), 32'h1);
        rd_chk("t1_cnt", 32'h10, 32'h1);

        // Fall enabled on bit7 only: the fall counts, the rises do not.
        wr(32'h04, 32'h80, 4'hF);
        gp[7] = 1'b1; wait_n(4);
        gp[7] = 1'b0; wait_n(4);
        gp[7] = 1'b1; wait_n(4);
        rd_chk("t2_status", 32'h08, 32'h81);
        rd_chk("t2_cnt", 32'h10, 32'h2);
        rd_chk("t2_level", 32'h14, 32'h81);

        // W1C colliding with a new bit0 event keeps the bit; a lone W1C clears it.
        wr(32'h08, 32'hFF, 4'hF);
        gp[0] = 1'b0; wait_n(4);
        gp[0] = 1'b1; wait_n(4);
        gp[0] = 1'b0; wait_n(4);
        gp[0] = 1'b1; wait_n(2);
        wr(32'h08, 32'h01, 4'hF);
        rd_chk("t3_status_keep", 32'h08, 32'h01);
        chk("t3_irq_keep", 32'(irq), 32'h1);
        wr(32'h08, 32'h01, 4'hF);
        wait_n(1);
        chk("t3_irq_clr", 32'(irq), 32'h0);
        rd_chk("t3_status_clr", 32'h08, 32'h00);

        // Counter saturation, clear, and clear colliding with an event.
        wr(32'h00, 32'hFF, 4'hF);
        wr(32'h04, 32'hFF, 4'hF);
        repeat (300) begin gp[1] = ~gp[1]; @(negedge clk); end
        wait_n(4);
        rd_chk("t4_sat", 32'h10, 32'hFF);
        wr(32'h10, 32'h0, 4'hF);
        rd_chk("t4_clr", 32'h10, 32'h0);
        gp[1] = ~gp[1]; wait_n(2);
        wr(32'h10, 32'h0, 4'hF);
        rd_chk("t4_clr_evt", 32'h10, 32'h1);

        // Byte lane beyond the implemented width, and an unmapped read.
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h00, 32'hFFFF_FFFF, 4'b0010);
        rd_chk("t5_be", 32'h00, 32'h0);
        rd_chk("t5_unmapped", 32'h20, 32'h0);

        // Reset mid-run with irq high and a read in flight.
        wr(32'h04, 32'h0, 4'hF);
        wr(32'h00, 32'h01, 4'hF);
        gp[0] = 1'b0; wait_n(4);
        gp[0] = 1'b1; wait_n(4);
        chk("t6_irq_pre", 32'(irq), 32'h1);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h08;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_irq_rst", 32'(irq), 32'h0);
        chk("t6_rvalid_rst", 32'(bus.rvalid), 32'h0);
        bus.req = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
        wr(32'h00, 32'h01, 4'hF);
        rd_chk("t6_status_r1", 32'h08, 32'h0);
        rd_chk("t6_status_r2", 32'h08, 32'h0);
        rd_chk("t6_status_r3", 32'h08, 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int b;
                b = $urandom_range(0, GW-1);
                gp[b] = ~gp[b];
            end
            if ($urandom_range(0, 1) == 1) begin
                bus.req   = 1'b1;
                bus.we    = 1'($urandom_range(0, 1));
                bus.addr  = ($urandom & 32'hFFFF_F000) | 32'(offs[$urandom_range(0, 7)]);
                bus.be    = 4'($urandom);
                bus.wdata = $urandom;
            end else begin
                bus.req = 1'b0;
            end
            @(negedge clk);
        end
        bus.req = 1'b0;
        wait_n(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
